// File: rtl/tilelink_slave_buffer.sv
// tilelink_slave_buffer
//   Elastic buffer for one crossbar slave port.
//   A channel: DEPTH-entry FIFO (up_a_* -> dn_a_*). The ready is registered
//     and never looks at dn_a_ready, so a full FIFO never accepts a flit.
//   D channel: with TL_D_SLICE_EN defined, a 2-entry skid slice with
//     registered dn_d_ready/up_d_valid. Without it, the D channel is plain wires.
// Ports
//   tilelink_clock_i    clock
//   tilelink_reset_i    asynchronous active-low reset
//   up_a_*              A flit from the crossbar, up_a_ready back to it
//   dn_a_*              A flit to the slave, dn_a_ready from it
//   dn_d_*              D flit from the slave, dn_d_ready back to it
//   up_d_*              D flit to the crossbar, up_d_ready from it
//   a_count             A-FIFO occupancy (0..DEPTH)
// Configuration macro: TL_D_SLICE_EN
//
// D slice states
//   state   | meaning
//   D_EMPTY | no flit held; dn_d_ready=1, up_d_valid=0
//   D_ONE   | head holds a flit; dn_d_ready=1, up_d_valid=1
//   D_TWO   | head and skid full; dn_d_ready=0, up_d_valid=1
module tilelink_slave_buffer #(
  parameter int TL_DW = 32,
  parameter int TL_AW = 32,
  parameter int TL_SZ = 4,
  parameter int SRC_W = 5,
  parameter int DEPTH = 4
) (
  input  logic                   tilelink_clock_i,
  input  logic                   tilelink_reset_i,
  input  logic [2:0]             up_a_opcode,
  input  logic [2:0]             up_a_param,
  input  logic [TL_SZ-1:0]       up_a_size,
  input  logic [SRC_W-1:0]       up_a_source,
  input  logic [TL_AW-1:0]       up_a_address,
  input  logic [TL_DW/8-1:0]     up_a_mask,
  input  logic [TL_DW-1:0]       up_a_data,
  input  logic                   up_a_corrupt,
  input  logic                   up_a_valid,
  output logic                   up_a_ready,
  output logic [2:0]             dn_a_opcode,
  output logic [2:0]             dn_a_param,
  output logic [TL_SZ-1:0]       dn_a_size,
  output logic [SRC_W-1:0]       dn_a_source,
  output logic [TL_AW-1:0]       dn_a_address,
  output logic [TL_DW/8-1:0]     dn_a_mask,
  output logic [TL_DW-1:0]       dn_a_data,
  output logic                   dn_a_corrupt,
  output logic                   dn_a_valid,
  input  logic                   dn_a_ready,
  input  logic [2:0]             dn_d_opcode,
  input  logic [1:0]             dn_d_param,
  input  logic [TL_SZ-1:0]       dn_d_size,
  input  logic [SRC_W-1:0]       dn_d_source,
  input  logic                   dn_d_denied,
  input  logic [TL_DW-1:0]       dn_d_data,
  input  logic                   dn_d_corrupt,
  input  logic                   dn_d_valid,
  output logic                   dn_d_ready,
  output logic [2:0]             up_d_opcode,
  output logic [1:0]             up_d_param,
  output logic [TL_SZ-1:0]       up_d_size,
  output logic [SRC_W-1:0]       up_d_source,
  output logic                   up_d_denied,
  output logic [TL_DW-1:0]       up_d_data,
  output logic                   up_d_corrupt,
  output logic                   up_d_valid,
  input  logic                   up_d_ready,
  output logic [$clog2(DEPTH):0] a_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AFW = 3 + 3 + TL_SZ + SRC_W + TL_AW + TL_DW/8 + TL_DW + 1;

  // ---------------- A channel FIFO ----------------
  logic [AFW-1:0] a_mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  a_count_q;
  logic [CW-1:0]  a_count_next;
  logic           a_ready_q;
  logic           a_push;
  logic           a_pop;

  assign dn_a_valid = (a_count_q != '0);
  assign a_push     = up_a_valid & a_ready_q;
  assign a_pop      = dn_a_valid & dn_a_ready;
  assign up_a_ready = a_ready_q;
  assign a_count    = a_count_q;

  always_comb begin
    a_count_next = a_count_q;
    case ({a_push, a_pop})
      2'b10:   a_count_next = a_count_q + CW'(1);
      2'b01:   a_count_next = a_count_q - CW'(1);
      default: a_count_next = a_count_q;
    endcase
  end

  // Ready is precomputed from the next occupancy so it equals
  // (a_count != DEPTH) every cycle yet comes straight from a flop.
  always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_i) begin
    if (!tilelink_reset_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      a_count_q <= '0;
      a_ready_q <= 1'b0;
    end else begin
      if (a_push) wr_ptr <= wr_ptr + PW'(1);
      if (a_pop)  rd_ptr <= rd_ptr + PW'(1);
      a_count_q <= a_count_next;
      a_ready_q <= (a_count_next != CW'(DEPTH));
    end
  end

  // Payload storage carries no reset.
  always_ff @(posedge tilelink_clock_i) begin
    if (a_push) begin
      a_mem[wr_ptr] <= {up_a_opcode, up_a_param, up_a_size, up_a_source,
                        up_a_address, up_a_mask, up_a_data, up_a_corrupt};
    end
  end

  assign {dn_a_opcode, dn_a_param, dn_a_size, dn_a_source,
          dn_a_address, dn_a_mask, dn_a_data, dn_a_corrupt} = a_mem[rd_ptr];

  // ---------------- D channel ----------------
`ifdef TL_D_SLICE_EN
  localparam int DFW = 3 + 2 + TL_SZ + SRC_W + 1 + TL_DW + 1;

  typedef enum logic [1:0] {D_EMPTY, D_ONE, D_TWO} d_state_e;

  d_state_e       d_state;
  logic [DFW-1:0] d_head;
  logic [DFW-1:0] d_skid;
  logic [DFW-1:0] d_in_flit;
  logic           d_rdy_q;
  logic           d_vld_q;
  logic           d_in;
  logic           d_out;

  assign d_in_flit  = {dn_d_opcode, dn_d_param, dn_d_size, dn_d_source,
                       dn_d_denied, dn_d_data, dn_d_corrupt};
  assign d_in       = dn_d_valid & d_rdy_q;
  assign d_out      = d_vld_q & up_d_ready;
  assign dn_d_ready = d_rdy_q;
  assign up_d_valid = d_vld_q;
  assign {up_d_opcode, up_d_param, up_d_size, up_d_source,
          up_d_denied, up_d_data, up_d_corrupt} = d_head;

  always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_i) begin
    if (!tilelink_reset_i) begin
      d_state <= D_EMPTY;
      d_rdy_q <= 1'b0;
      d_vld_q <= 1'b0;
    end else begin
      case (d_state)
        D_EMPTY: begin
          d_rdy_q <= 1'b1;
          if (d_in) begin
            d_state <= D_ONE;
            d_vld_q <= 1'b1;
          end else begin
            d_vld_q <= 1'b0;
          end
        end
        D_ONE: begin
          if (d_in && !d_out) begin
            d_state <= D_TWO;
            d_rdy_q <= 1'b0;
            d_vld_q <= 1'b1;
          end else if (d_out && !d_in) begin
            d_state <= D_EMPTY;
            d_rdy_q <= 1'b1;
            d_vld_q <= 1'b0;
          end else begin
            d_rdy_q <= 1'b1;
            d_vld_q <= 1'b1;
          end
        end
        D_TWO: begin
          d_vld_q <= 1'b1;
          if (d_out) begin
            d_state <= D_ONE;
            d_rdy_q <= 1'b1;
          end else begin
            d_rdy_q <= 1'b0;
          end
        end
        default: begin
          d_state <= D_EMPTY;
          d_rdy_q <= 1'b1;
          d_vld_q <= 1'b0;
        end
      endcase
    end
  end

  // Head is always the oldest flit; skid only fills when head cannot drain.
  always_ff @(posedge tilelink_clock_i) begin
    case (d_state)
      D_EMPTY: if (d_in) d_head <= d_in_flit;
      D_ONE: begin
        if (d_in && d_out) d_head <= d_in_flit;
        else if (d_in)     d_skid <= d_in_flit;
      end
      D_TWO:   if (d_out) d_head <= d_skid;
      default: ;
    endcase
  end
`else
  assign up_d_opcode  = dn_d_opcode;
  assign up_d_param   = dn_d_param;
  assign up_d_size    = dn_d_size;
  assign up_d_source  = dn_d_source;
  assign up_d_denied  = dn_d_denied;
  assign up_d_data    = dn_d_data;
  assign up_d_corrupt = dn_d_corrupt;
  assign up_d_valid   = dn_d_valid;
  assign dn_d_ready   = up_d_ready;
`endif

endmodule
